// File: rtl/dram_port_arbiter_pkg.sv
// Shared encodings for the MiniAlu data-memory port arbiter.
// States, port indices and the burst-counter width helper live here.
package dram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // A burst cap of 1 still needs a 1-bit counter that is permanently at its limit.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_burst_counter.sv
// Saturating locked-burst counter; clear wins over increment.
// at_max tells the arbiter the holder has used up its locked slots.
module dram_arb_burst_counter
  import dram_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = burst_cnt_width(MAX_BURST)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter (core = port 0, host = port 1) in front of the
// MiniAlu data RAM, with locked bursts, a burst cap and registered read return.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iReq0,
  input  logic          iWe0,
  input  logic          iLock0,
  input  logic [AW-1:0] iAddr0,
  input  logic [DW-1:0] iData0,
  output logic          oGnt0,
  output logic          oRdValid0,
  input  logic          iReq1,
  input  logic          iWe1,
  input  logic          iLock1,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iData1,
  output logic          oGnt1,
  output logic          oRdValid1,
  output logic          oRamWriteEnable,
  output logic [AW-1:0] oRamAddress,
  output logic [DW-1:0] oRamDataIn,
  input  logic [DW-1:0] iRamDataOut,
  output logic [DW-1:0] oRdData
);

  localparam int CW = burst_cnt_width(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid0_q, rd_valid0_d;
  logic          rd_valid1_q, rd_valid1_d;

  logic          xfer0, xfer1;
  logic          rd_xfer0, rd_xfer1;
  logic          burst_clr, burst_inc, burst_at_max;
  logic [CW-1:0] burst_cnt;

  assign xfer0    = (state_q == GNT0) && iReq0;
  assign xfer1    = (state_q == GNT1) && iReq1;
  assign rd_xfer0 = xfer0 && !iWe0;
  assign rd_xfer1 = xfer1 && !iWe1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (iReq0 && iReq1) begin
          state_d = (ptr_q == PORT_HOST) ? GNT1 : GNT0;
        end else if (iReq0) begin
          state_d = GNT0;
        end else if (iReq1) begin
          state_d = GNT1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!iReq0) begin
          state_d = iReq1 ? GNT1 : IDLE;
        end else if (iLock0) begin
          state_d = (iReq1 && burst_at_max) ? GNT1 : GNT0;
        end else begin
          state_d = iReq1 ? GNT1 : GNT0;
        end
      end
      GNT1: begin
        if (!iReq1) begin
          state_d = iReq0 ? GNT0 : IDLE;
        end else if (iLock1) begin
          state_d = (iReq0 && burst_at_max) ? GNT0 : GNT1;
        end else begin
          state_d = iReq0 ? GNT0 : GNT1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer0) begin
      ptr_d = PORT_HOST;
    end else if (xfer1) begin
      ptr_d = PORT_CORE;
    end
  end

  // Any grant change (including a forced switch at the cap) restarts the burst count.
  assign burst_inc = (xfer0 && iLock0) || (xfer1 && iLock1);
  assign burst_clr = (state_d != state_q) || (xfer0 && !iLock0) || (xfer1 && !iLock1);

  dram_arb_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_burst_counter (
    .clk    (Clock),
    .rst_n  (Reset),
    .clr    (burst_clr),
    .inc    (burst_inc),
    .cnt    (burst_cnt),
    .at_max (burst_at_max)
  );

  always_comb begin
    rd_valid0_d = rd_xfer0;
    rd_valid1_d = rd_xfer1;
    rd_data_d   = rd_data_q;
    if (rd_xfer0 || rd_xfer1) begin
      rd_data_d = iRamDataOut;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ptr_q       <= PORT_CORE;
      rd_data_q   <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
    end
  end

  // RAM side is driven straight from the registered state, so reset kills the strobe at once.
  always_comb begin
    oRamWriteEnable = 1'b0;
    oRamAddress     = '0;
    oRamDataIn      = '0;
    unique case (state_q)
      GNT0: begin
        oRamWriteEnable = iReq0 && iWe0;
        oRamAddress     = iAddr0;
        oRamDataIn      = iData0;
      end
      GNT1: begin
        oRamWriteEnable = iReq1 && iWe1;
        oRamAddress     = iAddr1;
        oRamDataIn      = iData1;
      end
      default: begin
        oRamWriteEnable = 1'b0;
        oRamAddress     = '0;
        oRamDataIn      = '0;
      end
    endcase
  end

  assign oGnt0     = (state_q == GNT0);
  assign oGnt1     = (state_q == GNT1);
  assign oRdValid0 = rd_valid0_q;
  assign oRdValid1 = rd_valid1_q;
  assign oRdData   = rd_data_q;

  logic unused_burst_cnt;
  assign unused_burst_cnt = ^burst_cnt;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: directed transfers push expected
// RAM accesses; a monitor pops and compares each observed transfer and read return.
module tb_dram_port_arbiter;

  logic        Clock;
  logic        Reset;
  logic        iReq0, iWe0, iLock0;
  logic [7:0]  iAddr0;
  logic [15:0] iData0;
  logic        oGnt0, oRdValid0;
  logic        iReq1, iWe1, iLock1;
  logic [7:0]  iAddr1;
  logic [15:0] iData1;
  logic        oGnt1, oRdValid1;
  logic        oRamWriteEnable;
  logic [7:0]  oRamAddress;
  logic [15:0] oRamDataIn;
  logic [15:0] iRamDataOut;
  logic [15:0] oRdData;

  logic [15:0] mem [0:255];

  typedef struct {
    int          port;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } xfer_t;

  xfer_t xq[$];
  xfer_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;

  dram_port_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .iReq0           (iReq0),
    .iWe0            (iWe0),
    .iLock0          (iLock0),
    .iAddr0          (iAddr0),
    .iData0          (iData0),
    .oGnt0           (oGnt0),
    .oRdValid0       (oRdValid0),
    .iReq1           (iReq1),
    .iWe1            (iWe1),
    .iLock1          (iLock1),
    .iAddr1          (iAddr1),
    .iData1          (iData1),
    .oGnt1           (oGnt1),
    .oRdValid1       (oRdValid1),
    .oRamWriteEnable (oRamWriteEnable),
    .oRamAddress     (oRamAddress),
    .oRamDataIn      (oRamDataIn),
    .iRamDataOut     (iRamDataOut),
    .oRdData         (oRdData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign iRamDataOut = mem[oRamAddress];
  always @(posedge Clock) begin
    if (oRamWriteEnable) mem[oRamAddress] <= oRamDataIn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  function automatic xfer_t mk(input int p, input logic we, input logic [7:0] a,
                               input logic [15:0] d);
    xfer_t e;
    e.port = p; e.we = we; e.addr = a; e.data = d;
    return e;
  endfunction

  // Request, hold until granted, return right after the transfer edge.
  task automatic do_xfer(input int p, input logic we, input logic lock,
                         input logic [7:0] a, input logic [15:0] d);
    int cyc;
    @(negedge Clock);
    if (p == 0) begin
      iReq0 = 1'b1; iWe0 = we; iLock0 = lock; iAddr0 = a; iData0 = d;
    end else begin
      iReq1 = 1'b1; iWe1 = we; iLock1 = lock; iAddr1 = a; iData1 = d;
    end
    cyc = 0;
    while ((((p == 0) ? oGnt0 : oGnt1) !== 1'b1) && (cyc < 50)) begin
      @(negedge Clock);
      cyc++;
    end
    if (cyc >= 50) fail_now($sformatf("grant_timeout_p%0d", p));
    @(posedge Clock);
  endtask

  task automatic rel(input int p);
    @(negedge Clock);
    if (p == 0) begin iReq0 = 1'b0; iLock0 = 1'b0; iWe0 = 1'b0; end
    else        begin iReq1 = 1'b0; iLock1 = 1'b0; iWe1 = 1'b0; end
  endtask

  // Monitor: samples after the drivers settle on the falling edge.
  always begin
    xfer_t e;
    @(negedge Clock);
    #2;
    chk("one_grant", {31'd0, oGnt0 & oGnt1}, 32'd0);
    chk("we_in_grant", {31'd0, oRamWriteEnable & ~(oGnt0 | oGnt1)}, 32'd0);
    if (oRdValid0 || oRdValid1) begin
      if (rq.size() == 0) begin
        fail_now("rd_unexpected");
      end else begin
        e = rq.pop_front();
        chk("rd_both", {31'd0, oRdValid0 & oRdValid1}, 32'd0);
        chk("rd_port", {31'd0, oRdValid1}, e.port);
        chk("rd_data", {16'd0, oRdData}, {16'd0, e.data});
      end
    end
    if ((oGnt0 && iReq0) || (oGnt1 && iReq1)) begin
      if (xq.size() == 0) begin
        fail_now("xfer_unexpected");
      end else begin
        e = xq.pop_front();
        chk("xfer_port", {31'd0, oGnt1}, e.port);
        chk("xfer_we", {31'd0, oRamWriteEnable}, {31'd0, e.we});
        chk("xfer_addr", {24'd0, oRamAddress}, {24'd0, e.addr});
        if (e.we) chk("xfer_wdata", {16'd0, oRamDataIn}, {16'd0, e.data});
        else      rq.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    iReq0 = 0; iWe0 = 0; iLock0 = 0; iAddr0 = 0; iData0 = 0;
    iReq1 = 0; iWe1 = 0; iLock1 = 0; iAddr1 = 0; iData1 = 0;
    repeat (3) @(negedge Clock);
    chk("rst_gnt0", {31'd0, oGnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, oGnt1}, 32'd0);
    chk("rst_rdv0", {31'd0, oRdValid0}, 32'd0);
    chk("rst_rdv1", {31'd0, oRdValid1}, 32'd0);
    chk("rst_rddata", {16'd0, oRdData}, 32'd0);
    chk("rst_we", {31'd0, oRamWriteEnable}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    // Simultaneous unlocked requests from reset alternate core, host, core, host.
    xq.push_back(mk(0, 1'b1, 8'h01, 16'h1111));
    xq.push_back(mk(1, 1'b1, 8'h02, 16'h2222));
    xq.push_back(mk(0, 1'b1, 8'h03, 16'h3333));
    xq.push_back(mk(1, 1'b1, 8'h04, 16'h4444));
    fork
      begin do_xfer(0, 1'b1, 1'b0, 8'h01, 16'h1111); do_xfer(0, 1'b1, 1'b0, 8'h03, 16'h3333); rel(0); end
      begin do_xfer(1, 1'b1, 1'b0, 8'h02, 16'h2222); do_xfer(1, 1'b1, 1'b0, 8'h04, 16'h4444); rel(1); end
    join
    repeat (3) @(negedge Clock);

    // Single core write, then back to idle.
    xq.push_back(mk(0, 1'b1, 8'h10, 16'h00AB));
    do_xfer(0, 1'b1, 1'b0, 8'h10, 16'h00AB);
    rel(0);
    #1 chk("single_no_we_after", {31'd0, oRamWriteEnable}, 32'd0);
    @(negedge Clock);
    chk("single_idle_gnt0", {31'd0, oGnt0}, 32'd0);
    chk("single_idle_gnt1", {31'd0, oGnt1}, 32'd0);
    repeat (2) @(negedge Clock);

    // Host write then read of 8'h05, then core read-back of 8'h10.
    xq.push_back(mk(1, 1'b1, 8'h05, 16'h1234));
    xq.push_back(mk(1, 1'b0, 8'h05, 16'h1234));
    do_xfer(1, 1'b1, 1'b0, 8'h05, 16'h1234);
    do_xfer(1, 1'b0, 1'b0, 8'h05, 16'h0000);
    rel(1);
    xq.push_back(mk(0, 1'b0, 8'h10, 16'h00AB));
    do_xfer(0, 1'b0, 1'b0, 8'h10, 16'h0000);
    rel(0);
    repeat (3) @(negedge Clock);

    // Locked host burst hits the cap of 4 while the core keeps requesting.
    for (int i = 0; i < 4; i++) xq.push_back(mk(1, 1'b1, 8'h20 + 8'(i), 16'hB000 + 16'(i)));
    xq.push_back(mk(0, 1'b1, 8'h30, 16'hC030));
    xq.push_back(mk(1, 1'b1, 8'h24, 16'hB004));
    xq.push_back(mk(1, 1'b1, 8'h25, 16'hB005));
    fork
      begin
        for (int i = 0; i < 5; i++) do_xfer(1, 1'b1, 1'b1, 8'h20 + 8'(i), 16'hB000 + 16'(i));
        do_xfer(1, 1'b1, 1'b0, 8'h25, 16'hB005);
        rel(1);
      end
      begin
        @(negedge Clock);
        do_xfer(0, 1'b1, 1'b0, 8'h30, 16'hC030);
        rel(0);
      end
    join
    repeat (3) @(negedge Clock);

    // Core withdraws while granted; host is waiting.
    xq.push_back(mk(1, 1'b1, 8'h41, 16'h4141));
    fork
      begin
        @(negedge Clock);
        iReq0 = 1'b1; iWe0 = 1'b1; iLock0 = 1'b0; iAddr0 = 8'h40; iData0 = 16'h4040;
        @(negedge Clock);
        chk("wd_gnt0", {31'd0, oGnt0}, 32'd1);
        iReq0 = 1'b0;
        #1 chk("wd_no_we", {31'd0, oRamWriteEnable}, 32'd0);
        @(negedge Clock);
        chk("wd_gnt1", {31'd0, oGnt1}, 32'd1);
        chk("wd_gnt0_off", {31'd0, oGnt0}, 32'd0);
        iWe0 = 1'b0;
      end
      begin do_xfer(1, 1'b1, 1'b0, 8'h41, 16'h4141); rel(1); end
    join
    repeat (3) @(negedge Clock);

    // Reset in the middle of a locked host burst (two transfers done).
    xq.push_back(mk(1, 1'b1, 8'h50, 16'h5050));
    xq.push_back(mk(1, 1'b1, 8'h51, 16'h5151));
    do_xfer(1, 1'b1, 1'b1, 8'h50, 16'h5050);
    do_xfer(1, 1'b1, 1'b1, 8'h51, 16'h5151);
    @(negedge Clock);
    #1 Reset = 1'b0;
    #1;
    chk("mrst_gnt1", {31'd0, oGnt1}, 32'd0);
    chk("mrst_gnt0", {31'd0, oGnt0}, 32'd0);
    chk("mrst_we", {31'd0, oRamWriteEnable}, 32'd0);
    chk("mrst_rdv1", {31'd0, oRdValid1}, 32'd0);
    @(negedge Clock);
    iReq1 = 1'b0; iLock1 = 1'b0; iWe1 = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    xq.push_back(mk(0, 1'b1, 8'h60, 16'h6060));
    xq.push_back(mk(1, 1'b1, 8'h61, 16'h6161));
    fork
      begin do_xfer(0, 1'b1, 1'b0, 8'h60, 16'h6060); rel(0); end
      begin do_xfer(1, 1'b1, 1'b0, 8'h61, 16'h6161); rel(1); end
    join
    repeat (4) @(negedge Clock);

    chk("xq_drained", xq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
